// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: segment
// patterns (active-high, bit order g..a), the all-off bus value and the
// sequencing FSM encoding.
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Active-low value that leaves every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_HEX_0 = 7'b0111111;
  localparam logic [6:0] SEG_HEX_1 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_2 = 7'b1011011;
  localparam logic [6:0] SEG_HEX_3 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_4 = 7'b1100110;
  localparam logic [6:0] SEG_HEX_5 = 7'b1101101;
  localparam logic [6:0] SEG_HEX_6 = 7'b1111101;
  localparam logic [6:0] SEG_HEX_7 = 7'b0000111;
  localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
  localparam logic [6:0] SEG_HEX_9 = 7'b1101111;
  localparam logic [6:0] SEG_HEX_A = 7'b1110111;
  localparam logic [6:0] SEG_HEX_B = 7'b1111100;
  localparam logic [6:0] SEG_HEX_C = 7'b0111001;
  localparam logic [6:0] SEG_HEX_D = 7'b1011110;
  localparam logic [6:0] SEG_HEX_E = 7'b1111001;
  localparam logic [6:0] SEG_HEX_F = 7'b1110001;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-high segment pattern (g..a).
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Full hex decode; every nibble value maps to a defined pattern.
  always_comb begin
    pattern = 7'b0000000;
    case (nibble)
      4'h0:    pattern = SEG_HEX_0;
      4'h1:    pattern = SEG_HEX_1;
      4'h2:    pattern = SEG_HEX_2;
      4'h3:    pattern = SEG_HEX_3;
      4'h4:    pattern = SEG_HEX_4;
      4'h5:    pattern = SEG_HEX_5;
      4'h6:    pattern = SEG_HEX_6;
      4'h7:    pattern = SEG_HEX_7;
      4'h8:    pattern = SEG_HEX_8;
      4'h9:    pattern = SEG_HEX_9;
      4'hA:    pattern = SEG_HEX_A;
      4'hB:    pattern = SEG_HEX_B;
      4'hC:    pattern = SEG_HEX_C;
      4'hD:    pattern = SEG_HEX_D;
      4'hE:    pattern = SEG_HEX_E;
      4'hF:    pattern = SEG_HEX_F;
      default: pattern = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/seven_seg_mux_ctrl.sv
// Multiplexed N-digit seven-segment driver. A BLANK/SHOW sequencer walks
// the digits; each digit is preceded by an all-off gap to stop ghosting.
// Inputs are captured once per frame so a frame never mixes two values.
// Brightness is a 16-level PWM on the top four bits of the dwell counter.
module seven_seg_mux_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int DWELL_W      = 10,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_suppress,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_pulse
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DWELL_W-1:0] CNT_MAX    = {DWELL_W{1'b1}};
  localparam logic [DWELL_W-1:0] BLANK_LAST = DWELL_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

  state_t               state_r, state_nxt_s;
  logic [DWELL_W-1:0]   cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]     idx_r, idx_nxt_s;
  logic                 load_s;

  logic [4*DIGITS-1:0]  din_snap_r;
  logic [DIGITS-1:0]    dp_snap_r;
  logic                 lz_snap_r;
  logic [3:0]           bright_snap_r;

  logic [3:0]           nibble_s;
  logic [6:0]           pattern_s;
  logic                 dp_bit_s;
  logic                 supp_s;
  logic                 zero_run_s;
  logic                 lit_s;

  logic [6:0]           seg_nxt_s;
  logic                 dp_nxt_s;
  logic [DIGITS-1:0]    sel_nxt_s;

  logic [6:0]           seg_r;
  logic                 dp_r;
  logic [DIGITS-1:0]    sel_r;
  logic                 frame_pulse_r;

  // Frame starts at the first gap of digit 0; this is the only capture point.
  assign load_s = (state_r == BLANK) && (idx_r == {IDX_W{1'b0}}) &&
                  (cnt_r == {DWELL_W{1'b0}});

  // Sequencer next state: gap, then dwell, then step to the next digit.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + DWELL_W'(1);
    idx_nxt_s   = idx_r;
    case (state_r)
      BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_nxt_s = SHOW;
          cnt_nxt_s   = {DWELL_W{1'b0}};
        end else begin
          state_nxt_s = BLANK;
        end
      end
      SHOW: begin
        if (cnt_r == CNT_MAX) begin
          state_nxt_s = BLANK;
          cnt_nxt_s   = {DWELL_W{1'b0}};
          idx_nxt_s   = (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end else begin
          state_nxt_s = SHOW;
        end
      end
      default: begin
        state_nxt_s = BLANK;
        cnt_nxt_s   = {DWELL_W{1'b0}};
        idx_nxt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= BLANK;
      cnt_r   <= {DWELL_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Per-frame snapshot of everything that affects what is displayed.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      din_snap_r    <= {(4*DIGITS){1'b0}};
      dp_snap_r     <= {DIGITS{1'b0}};
      lz_snap_r     <= 1'b0;
      bright_snap_r <= 4'h0;
    end else if (load_s) begin
      din_snap_r    <= din;
      dp_snap_r     <= dp_in;
      lz_snap_r     <= lz_suppress;
      bright_snap_r <= brightness;
    end else begin
      din_snap_r    <= din_snap_r;
      dp_snap_r     <= dp_snap_r;
      lz_snap_r     <= lz_snap_r;
      bright_snap_r <= bright_snap_r;
    end
  end

  // Select the active digit's nibble and dp; a digit is a leading zero when
  // it and every more significant digit are zero (digit 0 always shows).
  always_comb begin
    nibble_s   = 4'h0;
    dp_bit_s   = 1'b0;
    supp_s     = 1'b0;
    zero_run_s = lz_snap_r;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s & (din_snap_r[4*i +: 4] == 4'h0);
      if (idx_r == IDX_W'(i)) begin
        nibble_s = din_snap_r[4*i +: 4];
        dp_bit_s = dp_snap_r[i];
        supp_s   = zero_run_s && (i != 0);
      end else begin
        nibble_s = nibble_s;
      end
    end
  end

  seven_seg_decoder u_decoder (
    .nibble  (nibble_s),
    .pattern (pattern_s)
  );

  // PWM: lit for the first `brightness` sixteenths of the dwell; 15 is solid.
  assign lit_s = (cnt_r[DWELL_W-1 -: 4] < bright_snap_r) || (bright_snap_r == 4'hF);

  // Output values for the current sequencer position, registered below.
  always_comb begin
    seg_nxt_s = SEG_OFF;
    dp_nxt_s  = 1'b1;
    sel_nxt_s = {DIGITS{1'b0}};
    if (state_r == SHOW) begin
      sel_nxt_s = DIGITS'(1'b1) << idx_r;
      if (lit_s) begin
        seg_nxt_s = supp_s ? SEG_OFF : ~pattern_s;
        dp_nxt_s  = ~dp_bit_s;
      end else begin
        seg_nxt_s = SEG_OFF;
        dp_nxt_s  = 1'b1;
      end
    end else begin
      sel_nxt_s = {DIGITS{1'b0}};
    end
  end

  // Output registers; frame_pulse follows the capture edge by one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_r         <= SEG_OFF;
      dp_r          <= 1'b1;
      sel_r         <= {DIGITS{1'b0}};
      frame_pulse_r <= 1'b0;
    end else begin
      seg_r         <= seg_nxt_s;
      dp_r          <= dp_nxt_s;
      sel_r         <= sel_nxt_s;
      frame_pulse_r <= load_s;
    end
  end

  assign seg         = seg_r;
  assign dp          = dp_r;
  assign digit_sel   = sel_r;
  assign frame_pulse = frame_pulse_r;

endmodule

// File: tb/tb_seven_seg_mux_ctrl.sv
// Scoreboard bench: the stimulus process pushes the display settings it
// expects the next frame to capture; the monitor pops one entry per
// frame_pulse and compares every cycle of that frame to a reference model.
module tb_seven_seg_mux_ctrl;

  localparam int DIGITS       = 4;
  localparam int DWELL_W      = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int SHOW_LEN     = 16;
  localparam int SLOT         = BLANK_CYCLES + SHOW_LEN;
  localparam int FRAME        = DIGITS * SLOT;
  localparam int N_DIRECTED   = 8;
  localparam int N_FRAMES     = 24;

  typedef struct packed {
    logic [15:0] din;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  br;
  } frame_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] din = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  brightness = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_sel;
  logic        frame_pulse;

  frame_t exp_q[$];
  frame_t directed[N_DIRECTED];
  int     checks = 0;
  int     passes = 0;

  seven_seg_mux_ctrl #(
    .DIGITS       (DIGITS),
    .DWELL_W      (DWELL_W),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .din         (din),
    .dp_in       (dp_in),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .seg         (seg),
    .dp          (dp),
    .digit_sel   (digit_sel),
    .frame_pulse (frame_pulse)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [6:0] hex_pattern(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  4'hF: return 7'b1110001;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected {seg, dp, digit_sel} at cycle t of a frame (t=0 is the pulse cycle).
  function automatic logic [11:0] expect_out(input frame_t f, input int t);
    int d, w, s;
    logic [3:0] nib;
    logic lit, supp;
    logic [6:0] sg;
    d = t / SLOT;
    w = t % SLOT;
    if (w < BLANK_CYCLES) return {7'h7F, 1'b1, 4'h0};
    s    = w - BLANK_CYCLES;
    nib  = 4'((f.din >> (4 * d)) & 16'h000F);
    lit  = (s < int'(f.br)) || (f.br == 4'hF);
    supp = f.lz && (d > 0) && ((f.din >> (4 * d)) == 16'h0000);
    if (!lit) return {7'h7F, 1'b1, 4'(1 << d)};
    sg = supp ? 7'h7F : ~hex_pattern(nib);
    return {sg, ~f.dp[d], 4'(1 << d)};
  endfunction

  function automatic frame_t mk(input logic [15:0] d, input logic [3:0] p,
                                input logic l, input logic [3:0] b);
    frame_t f;
    f.din = d; f.dp = p; f.lz = l; f.br = b;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    int k;
    k     = $urandom_range(0, 4);
    f.din = 16'($urandom() >> (4 * k + 16));
    f.dp  = 4'($urandom());
    f.lz  = 1'($urandom());
    f.br  = 4'($urandom());
    return f;
  endfunction

  task automatic apply(input frame_t f);
    din = f.din; dp_in = f.dp; lz_suppress = f.lz; brightness = f.br;
  endtask

  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge CLK); #2;
      if (frame_pulse) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Monitor: one expected frame per frame_pulse, compared cycle by cycle.
  initial begin
    frame_t cur;
    int t;
    bit active;
    active = 1'b0;
    t = 0;
    cur = '0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        active = 1'b0;
      end else if (frame_pulse) begin
        if (active) check("frame_period", t + 1, FRAME);
        check("queue_depth_at_pulse", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          active = 1'b1;
          t = 0;
          check($sformatf("out t=%0d din=%h", t, cur.din), {seg, dp, digit_sel},
                expect_out(cur, t));
        end else begin
          active = 1'b0;
        end
      end else if (active) begin
        t++;
        if (t >= FRAME) begin
          check("pulse_missing", frame_pulse, 1);
          active = 1'b0;
        end else begin
          check($sformatf("out t=%0d din=%h br=%0d", t, cur.din, cur.br),
                {seg, dp, digit_sel}, expect_out(cur, t));
        end
      end
    end
  end

  // Stimulus: reset checks, then directed frames followed by random ones.
  initial begin
    bit ok;
    frame_t nf;
    directed[0] = mk(16'h4321, 4'b0000, 1'b0, 4'd15);
    directed[1] = mk(16'h0038, 4'b1000, 1'b1, 4'd15);
    directed[2] = mk(16'h0000, 4'b0000, 1'b1, 4'd15);
    directed[3] = mk(16'h1111, 4'b0000, 1'b0, 4'd15);
    directed[4] = mk(16'h2222, 4'b0101, 1'b0, 4'd15);
    directed[5] = mk(16'h8888, 4'b1111, 1'b0, 4'd0);
    directed[6] = mk(16'h5A7F, 4'b0011, 1'b0, 4'd8);
    directed[7] = mk(16'h0B0C, 4'b0110, 1'b1, 4'd15);

    RST_N = 1'b0;
    apply(directed[0]);
    repeat (5) begin
      @(negedge CLK);
      check("reset_outputs", {seg, dp, digit_sel, frame_pulse}, {7'h7F, 1'b1, 4'h0, 1'b0});
    end
    exp_q.push_back(directed[0]);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("pulse_after_release", frame_pulse, 1);
    repeat (24) @(posedge CLK);
    #3 RST_N = 1'b0;
    #1 check("async_reset_midframe", {seg, dp, digit_sel, frame_pulse},
             {7'h7F, 1'b1, 4'h0, 1'b0});
    repeat (3) @(negedge CLK);
    check("reset_held", {seg, dp, digit_sel, frame_pulse}, {7'h7F, 1'b1, 4'h0, 1'b0});
    exp_q.delete();
    exp_q.push_back(directed[0]);
    RST_N = 1'b1;

    for (int f = 1; f < N_FRAMES; f++) begin
      wait_pulse(ok);
      if (!ok) begin
        check("pulse_timeout", frame_pulse, 1);
        break;
      end
      if (f < N_DIRECTED) begin
        repeat (20) @(posedge CLK);
        apply(directed[f]);
        exp_q.push_back(directed[f]);
      end else begin
        repeat ($urandom_range(1, 25)) @(posedge CLK);
        apply(rand_frame());
        repeat ($urandom_range(1, 25)) @(posedge CLK);
        nf = rand_frame();
        apply(nf);
        exp_q.push_back(nf);
      end
    end
    wait_pulse(ok);
    if (!ok) check("pulse_timeout_last", frame_pulse, 1);
    repeat (FRAME - 4) @(posedge CLK);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_mux_ctrl.md
Name: seven_seg_mux_ctrl

Overview:
Parametrised multiplexed seven-segment driver for N hex digits on one shared segment bus.
- Drives one-hot digit enables in turn, with per-digit decimal points and leading-zero suppression.
- 16-level brightness PWM.
- Inter-digit blanking to prevent ghosting.
- Snapshots the display value once per frame so a digit never tears.
- Sits between the stopwatch/timer counters and the Pmod pins; replaces fixed two-digit controllers.

Parameters:
- DIGITS, 2: number of multiplexed digits (1..8); digit 0 is least significant.
- DWELL_W, 10: each digit is lit for 2^DWELL_W cycles; must be >= 4.
- BLANK_CYCLES, 16: all-off gap before each digit (>= 1).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- din  in  4*DIGITS  hex nibbles; nibble i = digit i.
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- lz_suppress  in  1  1 = blank leading zero digits.
- brightness  in  4  0 = dark, 15 = full on.
- seg  out  7  segments g..a, active-low.
- dp  out  1  decimal point, active-low.
- digit_sel  out  DIGITS  one-hot digit enable, active-high.
- frame_pulse  out  1  one-cycle strobe marking a new frame snapshot.

Behaviour:
- Reset is asynchronous, active-low. While RST_N=0:
  - state=BLANK, idx=0, cnt=0, snapshots cleared.
  - Outputs: seg=7'h7F, dp=1, digit_sel=0, frame_pulse=0.
  - Reset asserted mid-frame returns to these values immediately; no partial frame resumes.
- FSM states BLANK and SHOW, driven by a shared cycle counter cnt (DWELL_W bits).
  - BLANK: lasts BLANK_CYCLES cycles, then go to SHOW with cnt=0.
  - SHOW: lasts 2^DWELL_W cycles. Then idx advances (DIGITS-1 wraps to 0) and the FSM returns to BLANK.
- Load condition: state=BLANK, idx=0, cnt=0. This includes the first edge after reset release.
  - On load: snapshot din, dp_in, lz_suppress and brightness.
  - frame_pulse=1 for exactly the following cycle.
  - Input changes between loads have no visible effect.
- Frame period = DIGITS*(BLANK_CYCLES + 2^DWELL_W) cycles.
- All outputs are registered and lag state/cnt by exactly one cycle.
- During BLANK: seg=7'h7F, dp=1, digit_sel=0.
- During SHOW: digit_sel = 1<<idx, always (independent of brightness or suppression).
  - Lit condition: (cnt[DWELL_W-1:DWELL_W-4] < brightness_snap) OR (brightness_snap == 15).
  - When lit: seg = ~decode(nibble idx) and dp = ~dp_snap[idx].
  - Otherwise: seg=7'h7F, dp=1.
- Leading-zero suppression applies when lz_snap=1.
  - Digit i is suppressed if it and every higher digit are zero.
  - Digit 0 is never suppressed.
  - A suppressed digit outputs seg=7'h7F, but its dp still follows dp_snap.
- Decode is full hex, bit order g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- No X propagation: every decode case is defined.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16 segment pattern constants;
  - SEG_OFF = 7'h7F;
  - FSM state encoding (BLANK, SHOW).
- Sub-module seven_seg_decoder: combinational nibble to segment pattern (active-high), instantiated once and fed by the idx-selected snapshot nibble.
- Leading-zero logic and PWM compare stay inline.

Test Plan:
All tests use DIGITS=4, DWELL_W=4, BLANK_CYCLES=2.
1. Reset: hold RST_N=0 for 5 cycles, release, then reassert at cycle 30.
   -> seg=7F, dp=1, digit_sel=0, frame_pulse=0 during reset, immediately on reassertion (asynchronous).
   -> frame_pulse=1 on the 2nd cycle after release.
2. Sequencing: din=16'h4321, brightness=15, lz=0.
   -> digit_sel goes 0001, 0010, 0100, 1000, each lit 16 cycles, separated by 2 cycles of 0000.
   -> seg = 1111001 (1), 0100100 (2), 0110000 (3), 0011001 (4).
   -> frame_pulse period = 72 cycles.
3. Leading zeros: din=16'h0038, lz=1, dp_in=4'b1000.
   -> digit3 seg=7F with dp=0, digit2 seg=7F.
   -> digit1 seg=0110000, digit0 seg=0000000.
   -> With din=0: only digit0 shows 1000000.
4. Snapshot: change din from 16'h1111 to 16'h2222 mid-frame (during digit1).
   -> remaining digits of that frame still show 1.
   -> all digits show 2 only after the next frame_pulse.
5. Brightness: brightness=0.
   -> seg=7F for the whole frame while digit_sel still cycles.
   -> brightness=8: seg lit exactly 8 of 16 SHOW cycles per digit (the first 8).
   -> brightness=15: lit all 16.
